// File: rtl/intpol2_d4_y_drain_pkg.sv
// Shared definitions for the intpol2_D4 Y-memory drain.
//   state_t    : drain FSM state encoding
//   SKID_DEPTH : entries in the read-return skid buffer
package intpol2_d4_y_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/intpol2_d4_y_drain_if.sv
// Bus bundle between the drain, the Y memory read port and the output FIFO.
//   Y_rd_en / Y_raddr : read strobe and address towards Y memory
//   Y_rdata           : Y memory data, valid one cycle after Y_rd_en
//   fifo_wr / fifo_wdata : write strobe and data towards the output FIFO
//   fifo_full / fifo_afull : FIFO backpressure
// master = drain side, slave = memory/FIFO side.
interface intpol2_d4_y_drain_if #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 16
);

  logic                      Y_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] Y_raddr;
  logic [DATAPATH_WIDTH-1:0] Y_rdata;
  logic                      fifo_wr;
  logic [DATAPATH_WIDTH-1:0] fifo_wdata;
  logic                      fifo_full;
  logic                      fifo_afull;

  modport master (
    output Y_rd_en, Y_raddr, fifo_wr, fifo_wdata,
    input  Y_rdata, fifo_full, fifo_afull
  );

  modport slave (
    input  Y_rd_en, Y_raddr, fifo_wr, fifo_wdata,
    output Y_rdata, fifo_full, fifo_afull
  );

endinterface

// File: rtl/intpol2_d4_y_drain_skid2.sv
// Two-entry registered FIFO catching Y memory read returns.
//   push/din   : enqueue din
//   pop        : dequeue head (ignored when empty)
//   dout       : registered head entry (no din bypass)
//   count      : occupancy 0..2, empty/full flags
//   clear      : synchronous flush, same effect as rstn
module intpol2_d4_y_drain_skid2
  import intpol2_d4_y_drain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] entry0;  // head
  logic [WIDTH-1:0] entry1;
  logic             do_pop;

  assign dout   = entry0;
  assign empty  = (count == 2'd0);
  assign full   = (int'(count) == SKID_DEPTH);
  assign do_pop = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the data entries are reset as well so fifo_wdata reads 0 out of reset/clear.
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else if (clear) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (!full) begin
            if (empty) entry0 <= din;
            else       entry1 <= din;
            count <= count + 2'd1;
          end
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count unchanged; the new word lands behind whatever stays.
          if (count == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !clear) begin
      a_no_overflow: assert (!(push && full && !do_pop));
    end
  end

endmodule

// File: rtl/intpol2_d4_y_drain.sv
// intpol2_D4 Y drain: after the core finishes, reads olen samples from Y
// memory (1-cycle read latency) starting at Y_base and streams them into the
// output FIFO in address order, honouring fifo_full / fifo_afull.
//   clk, rstn      : clock, async active-low reset
//   clear          : synchronous soft reset, highest priority, aborts a drain
//   start/olen/Y_base : begin a drain (sampled in IDLE only)
//   bus            : Y memory read port + output FIFO write port
//   busy/done/ocnt : status, done pulses one cycle after the last FIFO write
// olen above 2^MEM_ADDR_WIDTH wraps the address and is unsupported.
module intpol2_d4_y_drain
  import intpol2_d4_y_drain_pkg::*;
#(
  parameter int DATAPATH_WIDTH = 32,
  parameter int CONFIG_WIDTH   = 32,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clear,
  input  logic                      start,
  input  logic [CONFIG_WIDTH-1:0]   olen,
  input  logic [MEM_ADDR_WIDTH-1:0] Y_base,
  intpol2_d4_y_drain_if.master      bus,
  output logic                      busy,
  output logic                      done,
  output logic [CONFIG_WIDTH-1:0]   ocnt
);

  state_t                    state;
  logic [CONFIG_WIDTH-1:0]   rem_rd;
  logic [MEM_ADDR_WIDTH-1:0] rd_ptr;
  logic                      inflight;

  logic [DATAPATH_WIDTH-1:0] skid_dout;
  logic [1:0]                skid_count;
  logic                      skid_empty;
  logic                      skid_full;

  logic                      issue;
  logic                      write;
  logic                      drain_end;

  assign write = !clear && !skid_empty && !bus.fifo_full;

  // A read may be issued when the skid buffer, after this cycle's FIFO write,
  // still has room for both the word already in flight and the new one.
  // Counting the concurrent write is what allows 1 sample/cycle.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    issue = 1'b0;
    if (!clear && state == RUN && rem_rd != '0 && !bus.fifo_afull &&
        (int'(skid_count) - int'(write) + int'(inflight)) < SKID_DEPTH) begin
      issue = 1'b1;
    end
  end

  // Nothing in flight and the skid buffer is empty by the end of this cycle.
  assign drain_end = !inflight && !skid_full && (skid_empty || write);

  assign bus.Y_rd_en    = issue;
  assign bus.Y_raddr    = rd_ptr;
  assign bus.fifo_wr    = write;
  assign bus.fifo_wdata = skid_dout;

  intpol2_d4_y_drain_skid2 #(.WIDTH(DATAPATH_WIDTH)) u_skid (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .push  (inflight),
    .pop   (write),
    .din   (bus.Y_rdata),
    .dout  (skid_dout),
    .count (skid_count),
    .empty (skid_empty),
    .full  (skid_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rem_rd   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      ocnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      rem_rd   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      ocnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inflight <= issue;
      done     <= 1'b0;
      if (write) ocnt <= ocnt + CONFIG_WIDTH'(1);
      if (issue) begin
        rd_ptr <= rd_ptr + MEM_ADDR_WIDTH'(1);
        rem_rd <= rem_rd - CONFIG_WIDTH'(1);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            rem_rd <= olen;
            rd_ptr <= Y_base;
            ocnt   <= '0;
            busy   <= 1'b1;
            // An empty drain still shows one busy cycle (in FLUSH) before FIN.
            state  <= (olen == '0) ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (issue && rem_rd == CONFIG_WIDTH'(1)) state <= FLUSH;
        end
        FLUSH: begin
          if (drain_end) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intpol2_d4_y_drain.sv
// Scoreboard bench for intpol2_d4_y_drain. Starting a drain queues the
// expected word stream Y[base+i mod 2^16]; a negedge monitor pops and checks
// every FIFO write, the done timing and the backpressure rules. A second
// instance with a 4-bit address checks address wrap.
module tb_intpol2_d4_y_drain;

  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int AW  = 16;
  localparam int AWW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] olen = '0;
  logic [AW-1:0] y_base = '0;
  logic          busy, done;
  logic [CW-1:0] ocnt;

  intpol2_d4_y_drain_if #(.DATAPATH_WIDTH(DW), .MEM_ADDR_WIDTH(AW)) y_if ();

  intpol2_d4_y_drain #(.DATAPATH_WIDTH(DW), .CONFIG_WIDTH(CW), .MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .start(start), .olen(olen), .Y_base(y_base),
    .bus(y_if), .busy(busy), .done(done), .ocnt(ocnt)
  );

  // Narrow-address instance for the wrap case.
  logic           w_start = 1'b0;
  logic [CW-1:0]  w_olen = '0;
  logic [AWW-1:0] w_base = '0;
  logic           w_busy, w_done;
  logic [CW-1:0]  w_ocnt;

  intpol2_d4_y_drain_if #(.DATAPATH_WIDTH(DW), .MEM_ADDR_WIDTH(AWW)) w_if ();

  intpol2_d4_y_drain #(.DATAPATH_WIDTH(DW), .CONFIG_WIDTH(CW), .MEM_ADDR_WIDTH(AWW)) dut_w (
    .clk(clk), .rstn(rstn), .clear(1'b0), .start(w_start), .olen(w_olen), .Y_base(w_base),
    .bus(w_if), .busy(w_busy), .done(w_done), .ocnt(w_ocnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Y memory models ----------------
  logic [15:0] salt = '0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {salt, a};
  endfunction

  always @(posedge clk) begin
    if (y_if.Y_rd_en) y_if.Y_rdata <= mem_val(y_if.Y_raddr);
    if (w_if.Y_rd_en) w_if.Y_rdata <= DW'(w_if.Y_raddr);
  end

  initial begin
    w_if.fifo_full  = 1'b0;
    w_if.fifo_afull = 1'b0;
  end

  // ---------------- backpressure driver ----------------
  int bp_mode = 0;  // 0 none, 1 random, 2 fixed pattern
  int bp_t0   = 0;

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1: begin
        y_if.fifo_full  = ($urandom_range(0, 3) == 0);
        y_if.fifo_afull = ($urandom_range(0, 4) == 0);
      end
      2: begin
        y_if.fifo_full  = (((cyc - bp_t0) / 3) % 2) == 1;
        y_if.fifo_afull = (cyc - bp_t0) >= 6 && (cyc - bp_t0) < 11;
      end
      default: begin
        y_if.fifo_full  = 1'b0;
        y_if.fifo_afull = 1'b0;
      end
    endcase
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  bit  drain_active  = 1'b0;
  bit  check_latency = 1'b0;
  int  exp_len = 0, start_cyc = 0, wr_cnt = 0, first_wr = 0, last_wr = 0;
  int  total_wr = 0, rd_cnt = 0, busy_cyc = 0;

  logic [AWW-1:0] w_addrs[$];
  logic [DW-1:0]  w_data[$];

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && !clear) begin
      if (y_if.fifo_afull) check("rd_en_under_afull", y_if.Y_rd_en, 0);
      if (y_if.fifo_full)  check("wr_under_full", y_if.fifo_wr, 0);
      check("skid_count_le2", dut.u_skid.count <= 2'd2, 1);
      if (y_if.Y_rd_en) rd_cnt++;
      if (busy) busy_cyc++;
      if (y_if.fifo_wr) begin
        total_wr++;
        check("wr_has_expectation", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("busy_during_wr", busy, 1);
          check("ocnt_before_wr", ocnt, wr_cnt);
          check("fifo_wdata", y_if.fifo_wdata, exp_q.pop_front());
          if (wr_cnt == 0) begin
            first_wr = cyc;
            if (check_latency) check("first_wr_latency", cyc - start_cyc, 3);
          end
          wr_cnt++;
          last_wr = cyc;
        end
      end
      if (done) begin
        check("done_expected", drain_active, 1);
        if (drain_active) begin
          check("done_ocnt", ocnt, exp_len);
          check("done_all_delivered", exp_q.size(), 0);
          check("busy_low_at_done", busy, 0);
          if (exp_len == 0) check("zero_len_done_delay", cyc - start_cyc, 2);
          else              check("done_after_last_wr", cyc - last_wr, 1);
          drain_active = 1'b0;
        end
      end
    end
    if (rstn) begin
      if (w_if.Y_rd_en) w_addrs.push_back(w_if.Y_raddr);
      if (w_if.fifo_wr) w_data.push_back(w_if.fifo_wdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start(input int len, input logic [AW-1:0] base);
    exp_q.delete();
    for (int i = 0; i < len; i++)
      exp_q.push_back(mem_val(AW'((int'(base) + i) % (1 << AW))));
    start     = 1'b1;
    olen      = CW'(len);
    y_base    = base;
    exp_len   = len;
    start_cyc = cyc;
    wr_cnt    = 0;
    drain_active = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (drain_active && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", drain_active, 0);
    if (drain_active) begin
      clear = 1'b1;
      exp_q.delete();
      drain_active = 1'b0;
      step();
      clear = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ocnt"}, ocnt, 0);
    check({tag, "_rd_en"}, y_if.Y_rd_en, 0);
    check({tag, "_raddr"}, y_if.Y_raddr, 0);
    check({tag, "_fifo_wr"}, y_if.fifo_wr, 0);
    check({tag, "_fifo_wdata"}, y_if.fifo_wdata, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int r0, w0, b0, guard;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // Basic drain: Y[a] = a, 8 words from 0x0010, no backpressure.
    salt = '0;
    check_latency = 1'b1;
    issue_start(8, 16'h0010);
    wait_drain(100);
    check("basic_consecutive_writes", last_wr - first_wr, 7);
    check_latency = 1'b0;
    step();

    // Zero length.
    r0 = rd_cnt; w0 = total_wr; b0 = busy_cyc;
    issue_start(0, 16'h0040);
    wait_drain(10);
    repeat (2) step();
    check("zero_len_no_reads", rd_cnt - r0, 0);
    check("zero_len_no_writes", total_wr - w0, 0);
    check("zero_len_busy_cycles", busy_cyc - b0, 1);

    // Backpressure pattern: full toggles every 3 cycles, afull window of 5.
    salt = 16'hA5A5;
    bp_t0 = cyc;
    bp_mode = 2;
    issue_start(16, 16'h0100);
    wait_drain(300);
    bp_mode = 0;
    step();

    // Address wrap on the 4-bit instance.
    w_addrs.delete();
    w_data.delete();
    w_start = 1'b1; w_olen = 4; w_base = 4'hE;
    step();
    w_start = 1'b0;
    guard = 0;
    while (!w_done && guard < 40) begin step(); guard++; end
    check("wrap_done_seen", w_done, 1);
    check("wrap_read_count", w_addrs.size(), 4);
    check("wrap_write_count", w_data.size(), 4);
    for (int i = 0; i < 4 && i < w_addrs.size() && i < w_data.size(); i++) begin
      check("wrap_raddr", w_addrs[i], (14 + i) % 16);
      check("wrap_wdata", w_data[i], (14 + i) % 16);
    end
    step();

    // start during RUN is ignored: the original 12-word stream must complete.
    salt = 16'h0C0C;
    issue_start(12, 16'h0300);
    step();
    start = 1'b1; olen = 5; y_base = 16'h7777;
    step();
    start = 1'b0;
    wait_drain(100);
    step();

    // Abort with clear on the 5th write, then a 3-word drain.
    salt = 16'h5151;
    issue_start(10, 16'h0200);
    guard = 0;
    while (!(y_if.fifo_wr && wr_cnt == 4) && guard < 100) begin step(); guard++; end
    check("abort_reached_5th_write", wr_cnt, 4);
    clear = 1'b1;
    exp_q.delete();
    drain_active = 1'b0;
    step();
    clear = 1'b0;
    check_idle_outputs("after_clear");
    repeat (8) step();
    issue_start(3, 16'h0400);
    wait_drain(50);
    check("restart_write_count", wr_cnt, 3);
    step();

    // Randomised drains under random backpressure.
    bp_mode = 1;
    for (int k = 0; k < 6; k++) begin
      logic [AW-1:0] base;
      salt = 16'($urandom);
      base = (k % 2 == 0) ? AW'(16'hFFF0 + $urandom_range(0, 15)) : AW'($urandom);
      issue_start($urandom_range(1, 40), base);
      wait_drain(1000);
      step();
    end
    bp_mode = 0;
    step();

    // Asynchronous reset mid-drain clears outputs at once.
    issue_start(20, 16'h0500);
    repeat (6) step();
    #3 rstn = 1'b0;
    #1 check_idle_outputs("async_reset");
    exp_q.delete();
    drain_active = 1'b0;
    step();
    rstn = 1'b1;
    step();
    issue_start(5, 16'h0600);
    wait_drain(50);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
